// File: rtl/router_pkg.sv
// Shared router definitions: packet header layout, limits and
// the transmit FSM state encoding used by both router sides.
package router_pkg;

   localparam int DW       = 8;
   localparam int MAX_LEN  = 63;
   localparam int ADDR_W   = 2;
   localparam int LEN_W    = 6;
   localparam int IDX_W    = 6;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   localparam int ADDR_LSB = 0;
   localparam int ADDR_MSB = 1;
   localparam int LEN_LSB  = 2;
   localparam int LEN_MSB  = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HEADER,
      ST_PAYLOAD,
      ST_PARITY,
      ST_GAP
   } tx_state_t;

   function automatic logic [DW-1:0] make_header(
      input logic [ADDR_W-1:0] addr,
      input logic [LEN_W-1:0]  len
   );
      logic [DW-1:0] h;
      h = '0;
      h[ADDR_MSB:ADDR_LSB] = addr;
      h[LEN_MSB:LEN_LSB]   = len;
      return h;
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: one write port, combinational read,
// storage deliberately left without reset.
module router_tx_buf #(
   parameter int DW    = 8,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // capture one payload byte per accepted handshake
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router source-side transmitter: buffers a full payload, then
// sends header, payload and parity bytes, holding on busy.
module router_pkt_tx #(
   parameter int DW      = router_pkg::DW,
   parameter int MAX_LEN = router_pkg::MAX_LEN
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_addr,
   input  logic [5:0]    req_len,
   input  logic          pl_valid,
   output logic          pl_ready,
   input  logic [DW-1:0] pl_data,
   input  logic          busy,
   output logic [DW-1:0] data_out,
   output logic          pkt_valid,
   output logic          tx_done,
   output logic [DW-1:0] tx_parity,
   output logic          addr_err
);

   import router_pkg::*;

   tx_state_t        state;
   logic [LEN_W-1:0] len_q;
   logic [DW-1:0]    hdr_q;
   logic [DW-1:0]    par_q;
   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] rd_addr;
   logic [DW-1:0]    rd_data;
   logic [DW-1:0]    req_hdr;
   logic             pl_hs;
   logic             req_hs;

   assign pl_hs   = pl_valid && pl_ready;
   assign req_hs  = req_valid && req_ready;
   assign req_hdr = make_header(req_addr, req_len);

   // read one byte ahead so data_out can be registered
   always_comb begin
      rd_addr = idx + 6'd1;
      if (state == ST_HEADER) rd_addr = '0;
   end

   router_tx_buf #(
      .DW    (DW),
      .DEPTH (MAX_LEN + 1),
      .AW    (IDX_W)
   ) u_buf (
      .clk   (clk),
      .we    (pl_hs),
      .waddr (cnt),
      .wdata (pl_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // transmit FSM with all outputs registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         len_q     <= '0;
         hdr_q     <= '0;
         par_q     <= '0;
         cnt       <= '0;
         idx       <= '0;
         req_ready <= 1'b0;
         pl_ready  <= 1'b0;
         data_out  <= '0;
         pkt_valid <= 1'b0;
         tx_done   <= 1'b0;
         tx_parity <= '0;
         addr_err  <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         addr_err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               req_ready <= 1'b1;
               if (req_hs) begin
                  if (req_addr == ADDR_INVALID) begin
                     addr_err <= 1'b1;
                  end else begin
                     len_q     <= req_len;
                     hdr_q     <= req_hdr;
                     par_q     <= req_hdr;
                     cnt       <= '0;
                     idx       <= '0;
                     req_ready <= 1'b0;
                     if (req_len != '0) begin
                        state    <= ST_LOAD;
                        pl_ready <= 1'b1;
                     end else begin
                        state     <= ST_HEADER;
                        data_out  <= req_hdr;
                        pkt_valid <= 1'b1;
                     end
                  end
               end
            end
            ST_LOAD: begin
               if (pl_hs) begin
                  par_q <= par_q ^ pl_data;
                  cnt   <= cnt + 6'd1;
                  if (cnt == len_q - 6'd1) begin
                     pl_ready  <= 1'b0;
                     state     <= ST_HEADER;
                     data_out  <= hdr_q;
                     pkt_valid <= 1'b1;
                  end
               end
            end
            ST_HEADER: begin
               if (!busy) begin
                  if (len_q != '0) begin
                     state    <= ST_PAYLOAD;
                     idx      <= '0;
                     data_out <= rd_data;
                  end else begin
                     state     <= ST_PARITY;
                     data_out  <= par_q;
                     pkt_valid <= 1'b0;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (!busy) begin
                  if (idx == len_q - 6'd1) begin
                     state     <= ST_PARITY;
                     data_out  <= par_q;
                     pkt_valid <= 1'b0;
                  end else begin
                     idx      <= idx + 6'd1;
                     data_out <= rd_data;
                  end
               end
            end
            ST_PARITY: begin
               if (!busy) begin
                  state     <= ST_GAP;
                  data_out  <= '0;
                  pkt_valid <= 1'b0;
                  tx_parity <= par_q;
                  tx_done   <= 1'b1;
               end
            end
            ST_GAP: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: randomized packets
// compared against a byte-sequence model of the router link.
module tb_router_pkt_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_addr = '0;
   logic [5:0] req_len = '0;
   logic       pl_valid = 1'b0;
   logic       pl_ready;
   logic [7:0] pl_data = '0;
   logic       busy = 1'b0;
   logic [7:0] data_out;
   logic       pkt_valid;
   logic       tx_done;
   logic [7:0] tx_parity;
   logic       addr_err;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0] obs_q[$];
   logic [8:0] exp_q[$];
   logic [7:0] exp_par;
   int         hold_bad;
   int         early_pv;
   int         timeout;
   logic [7:0] gap_data;
   logic [7:0] gap_par;
   logic       gap_pv;
   logic       gap_done;
   logic       post_ready;
   logic       post_done;

   router_pkt_tx dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .pl_valid  (pl_valid),
      .pl_ready  (pl_ready),
      .pl_data   (pl_data),
      .busy      (busy),
      .data_out  (data_out),
      .pkt_valid (pkt_valid),
      .tx_done   (tx_done),
      .tx_parity (tx_parity),
      .addr_err  (addr_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // link-level model: header, payload, parity as a byte list
   function automatic void build_exp(input logic [1:0] a,
                                     input logic [5:0] l,
                                     input logic [7:0] pl[$]);
      logic [7:0] h;
      logic [7:0] p;
      h = 8'(int'(l) * 4 + int'(a));
      p = h;
      exp_q.delete();
      exp_q.push_back({1'b1, h});
      foreach (pl[i]) begin
         exp_q.push_back({1'b1, pl[i]});
         p = p ^ pl[i];
      end
      exp_q.push_back({1'b0, p});
      exp_par = p;
   endfunction

   task automatic clear_obs();
      obs_q.delete();
      hold_bad = 0;
      early_pv = 0;
      timeout  = 0;
   endtask

   task automatic drive_req(input logic [1:0] a, input logic [5:0] l);
      bit acc;
      int t;
      acc = 0;
      t = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      req_len   = l;
      while (!acc && t < 200) begin
         acc = (req_ready === 1'b1);
         @(posedge clk);
         t++;
         if (!acc) @(negedge clk);
      end
      if (!acc) timeout++;
      #1;
      req_valid = 1'b0;
      req_addr  = 2'($urandom);
      req_len   = 6'($urandom);
   endtask

   task automatic drive_load(input logic [7:0] pl[$], input int gap_pct);
      int k;
      int t;
      bit acc;
      k = 0;
      t = 0;
      while (k < pl.size() && t < 2000) begin
         @(negedge clk);
         if (pkt_valid !== 1'b0) early_pv++;
         busy     = 1'($urandom_range(0, 1));
         pl_valid = ($urandom_range(0, 99) >= gap_pct);
         pl_data  = pl_valid ? pl[k] : 8'($urandom);
         acc = pl_valid && (pl_ready === 1'b1);
         @(posedge clk);
         t++;
         if (acc) k++;
      end
      if (k < pl.size()) timeout++;
      #1;
      pl_valid = 1'b0;
      busy     = 1'b0;
   endtask

   task automatic drive_trace(input int nbytes, input int stall[$]);
      for (int b = 0; b < nbytes; b++) begin
         int ns;
         logic [8:0] first;
         ns = (b < stall.size()) ? stall[b] : 0;
         first = '0;
         for (int s = 0; s <= ns; s++) begin
            @(negedge clk);
            if (s == 0) first = {pkt_valid, data_out};
            else if ({pkt_valid, data_out} !== first) hold_bad++;
            busy = (s < ns);
         end
         obs_q.push_back(first);
      end
      @(negedge clk);
      gap_data = data_out;
      gap_pv   = pkt_valid;
      gap_done = tx_done;
      gap_par  = tx_parity;
      busy     = 1'($urandom_range(0, 1));
      @(negedge clk);
      post_ready = req_ready;
      post_done  = tx_done;
      busy       = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({data_out, pkt_valid, req_ready, pl_ready,
           tx_done, tx_parity, addr_err} !== 21'd0) begin
         n_err++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {data_out, pkt_valid, req_ready, pl_ready,
                   tx_done, tx_parity, addr_err});
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || pl_ready !== 1'b0 || pkt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle got rr=%b pr=%b pv=%b exp 1 0 0",
                  req_ready, pl_ready, pkt_valid);
      end
   endtask

   task automatic test_basic();
      logic [7:0] pl[$];
      int st[$];
      pl = '{8'h11, 8'h22, 8'h33};
      for (int pass = 0; pass < 2; pass++) begin
         st.delete();
         if (pass == 1) st = '{3, 0, 2, 0, 0};
         build_exp(2'd1, 6'd3, pl);
         clear_obs();
         drive_req(2'd1, 6'd3);
         drive_load(pl, 30);
         drive_trace(5, st);
         n_cmp++;
         if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL basic%0d_count got=%0d exp=%0d",
                     pass, obs_q.size(), exp_q.size());
         end
         foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL basic%0d_byte%0d got=%h exp=%h",
                        pass, i, obs_q[i], exp_q[i]);
            end
         end
         n_cmp++;
         if ({gap_pv, gap_data, gap_done, gap_par} !==
             {1'b0, 8'h00, 1'b1, 8'h0D}) begin
            n_err++;
            $display("FAIL basic%0d_gap got pv=%b d=%h done=%b par=%h exp 0 00 1 0d",
                     pass, gap_pv, gap_data, gap_done, gap_par);
         end
         n_cmp++;
         if (hold_bad != 0 || early_pv != 0 || timeout != 0 ||
             post_ready !== 1'b1 || post_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic%0d_flow got hold=%0d early=%0d to=%0d rr=%b done=%b exp 0 0 0 1 0",
                     pass, hold_bad, early_pv, timeout, post_ready, post_done);
         end
      end
   endtask

   task automatic test_addr_err();
      int bad_pr;
      bad_pr = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 2'd3;
      req_len   = 6'd5;
      pl_valid  = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n_cmp++;
      if (addr_err !== 1'b1 || req_ready !== 1'b1 || pkt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL addr_err_pulse got err=%b rr=%b pv=%b exp 1 1 0",
                  addr_err, req_ready, pkt_valid);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (pl_ready !== 1'b0 || pkt_valid !== 1'b0 || addr_err !== 1'b0)
            bad_pr++;
      end
      pl_valid = 1'b0;
      n_cmp++;
      if (bad_pr != 0) begin
         n_err++;
         $display("FAIL addr_err_after got bad_cycles=%0d exp=0", bad_pr);
      end
   endtask

   task automatic test_len0();
      logic [7:0] pl[$];
      int st[$];
      pl.delete();
      st = '{1, 2};
      build_exp(2'd2, 6'd0, pl);
      clear_obs();
      drive_req(2'd2, 6'd0);
      drive_trace(2, st);
      n_cmp++;
      if (obs_q.size() != 2 || obs_q[0] !== 9'h102 || obs_q[1] !== 9'h002) begin
         n_err++;
         $display("FAIL len0_bytes got=%h %h exp=102 002", obs_q[0], obs_q[1]);
      end
      n_cmp++;
      if ({gap_pv, gap_data, gap_done, gap_par} !==
          {1'b0, 8'h00, 1'b1, exp_par} || hold_bad != 0 || timeout != 0) begin
         n_err++;
         $display("FAIL len0_gap got pv=%b d=%h done=%b par=%h hold=%0d exp 0 00 1 %h 0",
                  gap_pv, gap_data, gap_done, gap_par, hold_bad, exp_par);
      end
   endtask

   task automatic test_random(input int npkt, input bit force_max);
      for (int n = 0; n < npkt; n++) begin
         logic [7:0] pl[$];
         int st[$];
         logic [1:0] a;
         logic [5:0] l;
         int errs;
         a = 2'($urandom_range(0, 2));
         l = force_max ? 6'd63 : 6'($urandom_range(0, 63));
         pl.delete();
         st.delete();
         for (int i = 0; i < int'(l); i++) pl.push_back(8'($urandom));
         for (int i = 0; i < int'(l) + 2; i++)
            st.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
         build_exp(a, l, pl);
         clear_obs();
         drive_req(a, l);
         drive_load(pl, 40);
         drive_trace(int'(l) + 2, st);
         errs = 0;
         foreach (exp_q[i])
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) errs++;
         n_cmp++;
         if (errs != 0 || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand%0d_bytes len=%0d got bad=%0d n=%0d exp bad=0 n=%0d",
                     n, l, errs, obs_q.size(), exp_q.size());
         end
         n_cmp++;
         if ({gap_pv, gap_data, gap_done, gap_par} !==
             {1'b0, 8'h00, 1'b1, exp_par}) begin
            n_err++;
            $display("FAIL rand%0d_gap got pv=%b d=%h done=%b par=%h exp 0 00 1 %h",
                     n, gap_pv, gap_data, gap_done, gap_par, exp_par);
         end
         n_cmp++;
         if (hold_bad != 0 || early_pv != 0 || timeout != 0 ||
             post_ready !== 1'b1 || post_done !== 1'b0) begin
            n_err++;
            $display("FAIL rand%0d_flow got hold=%0d early=%0d to=%0d rr=%b done=%b exp 0 0 0 1 0",
                     n, hold_bad, early_pv, timeout, post_ready, post_done);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] pl[$];
      pl.delete();
      for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
      clear_obs();
      drive_req(2'd0, 6'd20);
      drive_load(pl, 20);
      for (int b = 0; b <= 11; b++) @(negedge clk);
      n_cmp++;
      if ({pkt_valid, data_out} !== {1'b1, pl[10]} || timeout != 0) begin
         n_err++;
         $display("FAIL rstmid_byte10 got=%h exp=%h", {pkt_valid, data_out},
                  {1'b1, pl[10]});
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({data_out, pkt_valid, req_ready, pl_ready,
           tx_done, tx_parity, addr_err} !== 21'd0) begin
         n_err++;
         $display("FAIL rstmid_async got=%h exp=0",
                  {data_out, pkt_valid, req_ready, pl_ready,
                   tx_done, tx_parity, addr_err});
      end
      @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b0 || data_out !== 8'h00) begin
         n_err++;
         $display("FAIL rstmid_held got pv=%b d=%h exp 0 00", pkt_valid, data_out);
      end
      rst = 1'b1;
      test_random(1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_addr_err();
      test_len0();
      test_random(1, 1'b1);
      test_random(6, 1'b0);
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
